// File: rtl/excpt_sched_pkg.sv
// rtl/excpt_sched_pkg.sv - exception-type codes, exccodes, state encoding and decode helper
package excpt_sched_pkg;

    localparam logic [31:0] ZERO_WORD   = 32'h0000_0000;

    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

    localparam logic [4:0]  EXCCODE_INT = 5'h00;
    localparam logic [4:0]  EXCCODE_SYS = 5'h08;
    localparam logic [4:0]  EXCCODE_RI  = 5'h0a;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRAIN = 2'd1,
        ST_FLUSH = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    typedef struct packed {
        logic [31:0] tgt;
        logic [4:0]  code;
        logic        eret;
    } dec_t;

    // A zero excptype only reaches decode when the internal irq is the
    // requester, so it shares the interrupt vector with EXC_INT.
    function automatic dec_t decode(input logic [31:0] excptype,
                                    input logic [31:0] epc,
                                    input logic [31:0] vec_exc,
                                    input logic [31:0] vec_int);
        dec_t d;
        d.tgt  = vec_exc;
        d.code = EXCCODE_RI;
        d.eret = 1'b0;
        case (excptype)
            EXC_SYSCALL: begin
                d.code = EXCCODE_SYS;
            end
            EXC_ERET: begin
                d.tgt  = epc;
                d.code = EXCCODE_INT;
                d.eret = 1'b1;
            end
            EXC_INT, ZERO_WORD: begin
                d.tgt  = vec_int;
                d.code = EXCCODE_INT;
            end
            default: ;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/excpt_sched.sv
// rtl/excpt_sched.sv - registered exception/interrupt sequencer with drain, flush and hold window
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   excptype, epc       MEM-stage exception type and its PC (saved EPC for eret)
//   int_req, ie, exl, im  interrupt lines and CP0 Status fields
//   stall_req           memory busy; flush is held off while high
//   flush, pc_we, ejpc  one-cycle pipeline flush and PC redirect
//   epc_we, epc_out     CP0 EPC write strobe and data
//   cause_we, exccode   CP0 Cause.ExcCode write strobe and data
//   exl_set, exl_clr    Status.EXL set/clear strobes
//   busy                sequence in progress; stalls IF/ID
module excpt_sched
    import excpt_sched_pkg::*;
#(
    parameter int unsigned HOLD_CYC = 2,
    parameter logic [31:0] VEC_EXC  = 32'h0000_0040,
    parameter logic [31:0] VEC_INT  = 32'h0000_0050
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] excptype,
    input  logic [31:0] epc,
    input  logic [5:0]  int_req,
    input  logic        ie,
    input  logic        exl,
    input  logic [5:0]  im,
    input  logic        stall_req,
    output logic        flush,
    output logic        pc_we,
    output logic [31:0] ejpc,
    output logic        epc_we,
    output logic [31:0] epc_out,
    output logic        cause_we,
    output logic [4:0]  exccode,
    output logic        exl_set,
    output logic        exl_clr,
    output logic        busy
);

    localparam logic [3:0] HOLD_LOAD = 4'(HOLD_CYC);

    state_t     state;
    state_t     state_nxt;
    logic [3:0] hold_cnt;
    logic       eret_q;
    logic       irq;
    logic       req;
    logic       capture;
    logic       go_flush;
    logic       cur_eret;
    dec_t       dec;

    assign irq      = (|(int_req & im)) & ie & ~exl;
    assign req      = (excptype != ZERO_WORD) | irq;
    assign dec      = decode(excptype, epc, VEC_EXC, VEC_INT);
    assign capture  = (state == ST_IDLE) & req;
    assign go_flush = (state_nxt == ST_FLUSH);
    // When flushing straight out of IDLE the class has not been latched yet.
    assign cur_eret = (state == ST_IDLE) ? dec.eret : eret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (req) state_nxt = stall_req ? ST_DRAIN : ST_FLUSH;
            ST_DRAIN: if (!stall_req) state_nxt = ST_FLUSH;
            ST_FLUSH: state_nxt = ST_HOLD;
            ST_HOLD:  if (hold_cnt == 4'd1) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flush    <= 1'b0;
            pc_we    <= 1'b0;
            epc_we   <= 1'b0;
            cause_we <= 1'b0;
            exl_set  <= 1'b0;
            exl_clr  <= 1'b0;
            busy     <= 1'b0;
            ejpc     <= ZERO_WORD;
            epc_out  <= ZERO_WORD;
            exccode  <= 5'd0;
            eret_q   <= 1'b0;
            hold_cnt <= 4'd0;
        end else begin
            flush    <= go_flush;
            pc_we    <= go_flush;
            epc_we   <= go_flush & ~cur_eret;
            cause_we <= go_flush & ~cur_eret;
            exl_set  <= go_flush & ~cur_eret;
            exl_clr  <= go_flush & cur_eret;
            busy     <= (state_nxt != ST_IDLE);

            if (capture) begin
                ejpc    <= dec.tgt;
                exccode <= dec.code;
                eret_q  <= dec.eret;
                epc_out <= epc;
            end

            if (state == ST_FLUSH) begin
                hold_cnt <= HOLD_LOAD;
            end else if (state == ST_HOLD) begin
                hold_cnt <= hold_cnt - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_excpt_sched.sv
// tb/tb_excpt_sched.sv - self-checking bench for excpt_sched with timeline model and directed cases
module tb_excpt_sched;

    localparam int          HOLD = 2;
    localparam logic [31:0] VEXC = 32'h40;
    localparam logic [31:0] VINT = 32'h50;

    logic        clk;
    logic        rst;
    logic [31:0] excptype;
    logic [31:0] epc;
    logic [5:0]  int_req;
    logic        ie;
    logic        exl;
    logic [5:0]  im;
    logic        stall_req;
    logic        flush;
    logic        pc_we;
    logic [31:0] ejpc;
    logic        epc_we;
    logic [31:0] epc_out;
    logic        cause_we;
    logic [4:0]  exccode;
    logic        exl_set;
    logic        exl_clr;
    logic        busy;

    excpt_sched #(.HOLD_CYC(HOLD), .VEC_EXC(VEXC), .VEC_INT(VINT)) dut (
        .clk(clk), .rst(rst), .excptype(excptype), .epc(epc), .int_req(int_req),
        .ie(ie), .exl(exl), .im(im), .stall_req(stall_req), .flush(flush),
        .pc_we(pc_we), .ejpc(ejpc), .epc_we(epc_we), .epc_out(epc_out),
        .cause_we(cause_we), .exccode(exccode), .exl_set(exl_set),
        .exl_clr(exl_clr), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Timeline model: an event is either waiting for the memory to drain,
    // being flushed this cycle, or inside its blackout window.
    bit          m_pend, m_flush_now;
    int          m_black;
    logic [31:0] e_tgt, e_epc;
    logic [4:0]  e_code;
    bit          e_eret;
    bit          x_flush, x_epc_we, x_exl_clr, x_busy;
    bit          m_irq;

    always begin
        @(posedge clk);
        if (rst) begin
            m_pend = 0; m_flush_now = 0; m_black = 0;
            e_tgt = 0; e_epc = 0; e_code = 0; e_eret = 0;
        end else if (m_flush_now) begin
            m_flush_now = 0;
            m_black = HOLD;
        end else if (m_black > 0) begin
            m_black--;
        end else if (m_pend) begin
            if (!stall_req) begin m_pend = 0; m_flush_now = 1; end
        end else begin
            m_irq = (|(int_req & im)) && ie && !exl;
            if (excptype != 0 || m_irq) begin
                e_epc = epc; e_eret = 0;
                if (excptype == 32'h8) begin e_tgt = VEXC; e_code = 5'h08; end
                else if (excptype == 32'he) begin e_tgt = epc; e_code = 5'h00; e_eret = 1; end
                else if (excptype == 32'h1 || excptype == 0) begin e_tgt = VINT; e_code = 5'h00; end
                else begin e_tgt = VEXC; e_code = 5'h0a; end
                if (stall_req) m_pend = 1; else m_flush_now = 1;
            end
        end
        x_flush   = m_flush_now;
        x_epc_we  = m_flush_now && !e_eret;
        x_exl_clr = m_flush_now && e_eret;
        x_busy    = m_pend || m_flush_now || (m_black > 0);
        #1;
        chk("flush", flush, x_flush);
        chk("pc_we", pc_we, x_flush);
        chk("epc_we", epc_we, x_epc_we);
        chk("cause_we", cause_we, x_epc_we);
        chk("exl_set", exl_set, x_epc_we);
        chk("exl_clr", exl_clr, x_exl_clr);
        chk("busy", busy, x_busy);
        chk("epc_out", epc_out, e_epc);
        if (x_flush) chk("ejpc", ejpc, e_tgt);
        if (x_epc_we) chk("exccode", exccode, e_code);
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic wait_flush(input int max, output int cycles);
        cycles = 0;
        while (!flush && cycles < max) begin
            tick();
            cycles++;
        end
        if (!flush) chk("wait_flush_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 40) begin
            tick();
            n++;
        end
        if (busy) chk("wait_idle_timeout", 32'd0, 32'd1);
        tick();
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, "_strobes"}, {25'd0, flush, pc_we, epc_we, cause_we, exl_set, exl_clr, busy}, 32'd0);
        chk({name, "_ejpc"}, ejpc, 32'd0);
        chk({name, "_epc_out"}, epc_out, 32'd0);
    endtask

    initial begin
        int c, dc, gap, r;
        rst = 1; excptype = 0; epc = 0; int_req = 0; ie = 0; exl = 0; im = 0; stall_req = 0;
        tick(); tick();
        chk_all_zero("reset");
        chk("reset_exccode", {27'd0, exccode}, 32'd0);
        rst = 0;
        tick();

        // syscall, no stall
        excptype = 32'h8; epc = 32'h100;
        wait_flush(10, c);
        excptype = 0;
        chk("sys_latency", c, 1);
        chk("sys_ejpc", ejpc, 32'h40);
        chk("sys_epc_out", epc_out, 32'h100);
        chk("sys_exccode", exccode, 32'h8);
        chk("sys_exl_set", exl_set, 1);
        dc = 0;
        while (busy && dc < 20) begin dc++; tick(); end
        chk("sys_busy_cycles", dc, HOLD + 1);
        tick();

        // eret with three drain cycles
        excptype = 32'he; epc = 32'h2c4; stall_req = 1;
        tick();
        excptype = 0; epc = 0; dc = 0;
        for (int i = 0; i < 3; i++) begin
            if (busy && !flush) dc++;
            if (i == 2) stall_req = 0; else tick();
        end
        wait_flush(10, c);
        chk("eret_drain_cycles", dc, 3);
        chk("eret_latency", c, 1);
        chk("eret_ejpc", ejpc, 32'h2c4);
        chk("eret_exl_clr", exl_clr, 1);
        chk("eret_epc_we", epc_we, 0);
        chk("eret_cause_we", cause_we, 0);
        wait_idle();

        // unmasked interrupt
        int_req = 6'b000100; im = 6'b000100; ie = 1; exl = 0;
        wait_flush(10, c);
        int_req = 0;
        chk("irq_ejpc", ejpc, 32'h50);
        chk("irq_exccode", exccode, 0);
        wait_idle();

        // interrupt blocked by EXL
        int_req = 6'b000100; exl = 1; dc = 0;
        for (int i = 0; i < 8; i++) begin tick(); if (busy) dc++; end
        chk("irq_exl_quiet", dc, 0);
        int_req = 0; exl = 0;
        tick();

        // syscall beats interrupt, interrupt follows after the hold window
        excptype = 32'h8; epc = 32'h200; int_req = 6'b000100;
        wait_flush(10, c);
        excptype = 0;
        chk("prio_first_exccode", exccode, 32'h8);
        chk("prio_first_ejpc", ejpc, 32'h40);
        gap = 0;
        do begin tick(); gap++; end while (!flush && gap < 20);
        chk("prio_gap", gap, HOLD + 2);
        chk("prio_second_ejpc", ejpc, 32'h50);
        int_req = 0;
        wait_idle();

        // unknown exception type
        excptype = 32'h3; epc = 32'h300;
        wait_flush(10, c);
        excptype = 0;
        chk("ri_ejpc", ejpc, 32'h40);
        chk("ri_exccode", exccode, 32'h0a);
        wait_idle();

        // reset during DRAIN
        excptype = 32'h8; epc = 32'h111; stall_req = 1;
        tick(); tick();
        chk("drain_busy", busy, 1);
        rst = 1; #1;
        chk_all_zero("rst_drain");
        excptype = 0; stall_req = 0;
        tick(); rst = 0; tick();
        excptype = 32'h8; epc = 32'h104;
        wait_flush(10, c);
        excptype = 0;
        chk("post_rst_ejpc", ejpc, 32'h40);
        chk("post_rst_epc_out", epc_out, 32'h104);
        wait_idle();

        // reset during HOLD
        excptype = 32'h8; epc = 32'h108;
        wait_flush(10, c);
        excptype = 0;
        tick();
        rst = 1; #1;
        chk_all_zero("rst_hold");
        tick(); rst = 0; tick();
        excptype = 32'h8; epc = 32'h10c;
        wait_flush(10, c);
        excptype = 0;
        chk("post_rst2_epc_out", epc_out, 32'h10c);
        wait_idle();

        // randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            rst = ($urandom_range(0, 299) == 0);
            r = $urandom_range(0, 15);
            case (r)
                9:       excptype = 32'h8;
                10:      excptype = 32'he;
                11:      excptype = 32'h1;
                12:      excptype = 32'h3;
                13:      excptype = $urandom;
                default: excptype = 0;
            endcase
            epc       = $urandom;
            stall_req = ($urandom_range(0, 2) == 0);
            int_req   = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            im        = 6'($urandom);
            ie        = 1'($urandom);
            exl       = 1'($urandom);
            tick();
        end
        rst = 0; excptype = 0; int_req = 0; stall_req = 0;
        tick(); tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
